// File: rtl/trena_tx_medida.sv
// trena_tx_medida: latches an N-digit BCD measurement on request and sends it
// MSB digit first as ASCII, followed by a terminator, over a 7E1 UART.
// Optional build macro TRENA_TX_CRLF_EN appends CR (0x0D) and LF (0x0A)
// after the terminator.
`timescale 1ns/1ps

module trena_tx_medida #(
    parameter int unsigned N_DIGITOS      = 3,
    parameter int unsigned CICLOS_POR_BIT = 434,
    parameter logic [6:0]  TERMINADOR     = 7'h23
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enviar,
    input  logic [4*N_DIGITOS-1:0] medida,
    output logic                   saida_serial,
    output logic                   ocupado,
    output logic                   pronto,
    output logic [2:0]             db_estado
);

    localparam int unsigned CW = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [CW-1:0] CICLO_MAX = CW'(CICLOS_POR_BIT - 1);
`ifdef TRENA_TX_CRLF_EN
    localparam logic [3:0] ULTIMO = 4'(N_DIGITOS + 2);
`else
    localparam logic [3:0] ULTIMO = 4'(N_DIGITOS);
`endif

    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] CARREGA = 3'd1;
    localparam logic [2:0] BITS    = 3'd2;
    localparam logic [2:0] PROXIMO = 3'd3;
    localparam logic [2:0] FIM     = 3'd4;

    logic [2:0]             estado;
    logic [4*N_DIGITOS-1:0] medida_reg;
    logic [3:0]             indice;
    logic [3:0]             contador_bits;
    logic [CW-1:0]          contador_ciclos;
    logic [9:0]             quadro;
    logic [3:0]             digito;
    logic [6:0]             caractere;

    // Pick the digit addressed by the index; index 0 is the most-significant digit.
    always_comb begin
        digito = 4'd0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (indice == 4'(N_DIGITOS - 1 - i)) begin
                digito = medida_reg[4*i +: 4];
            end
        end
    end

    // Map the current index to its 7-bit ASCII character.
    always_comb begin
        caractere = TERMINADOR;
        if (indice < 4'(N_DIGITOS)) begin
            caractere = (digito <= 4'd9) ? (7'h30 + {3'b000, digito}) : 7'h3F;
        end
`ifdef TRENA_TX_CRLF_EN
        else if (indice == 4'(N_DIGITOS + 1)) begin
            caractere = 7'h0D;
        end else if (indice == 4'(N_DIGITOS + 2)) begin
            caractere = 7'h0A;
        end
`endif
    end

    // Sequencer, bit timing and registered line output.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= OCIOSO;
            medida_reg      <= '0;
            indice          <= 4'd0;
            contador_bits   <= 4'd0;
            contador_ciclos <= '0;
            quadro          <= '0;
            saida_serial    <= 1'b1;
            pronto          <= 1'b0;
        end else begin
            // pronto follows FIM by one cycle so it marks the end of the idle FIM slot
            pronto <= (estado == FIM);
            case (estado)
                OCIOSO: begin
                    if (enviar) begin
                        medida_reg <= medida;
                        indice     <= 4'd0;
                        estado     <= CARREGA;
                    end
                end
                CARREGA: begin
                    quadro          <= {1'b1, ^caractere, caractere, 1'b0};
                    contador_bits   <= 4'd0;
                    contador_ciclos <= '0;
                    saida_serial    <= 1'b0;
                    estado          <= BITS;
                end
                BITS: begin
                    if (contador_ciclos == CICLO_MAX) begin
                        contador_ciclos <= '0;
                        if (contador_bits == 4'd9) begin
                            saida_serial <= 1'b1;
                            estado       <= (indice == ULTIMO) ? FIM : PROXIMO;
                        end else begin
                            // quadro shifts right; bit 1 is always the next bit to send
                            contador_bits <= contador_bits + 4'd1;
                            saida_serial  <= quadro[1];
                            quadro        <= {1'b1, quadro[9:1]};
                        end
                    end else begin
                        contador_ciclos <= contador_ciclos + 1'b1;
                    end
                end
                PROXIMO: begin
                    indice <= indice + 4'd1;
                    estado <= CARREGA;
                end
                FIM: begin
                    estado <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign ocupado   = (estado != OCIOSO) | pronto;
    assign db_estado = estado;

endmodule

// File: tb/tb_trena_tx_medida.sv
// Self-checking bench for trena_tx_medida (N_DIGITOS=3, CICLOS_POR_BIT=4).
// Honours TRENA_TX_CRLF_EN when the bundle is built with it.
`timescale 1ns/1ps

module tb_trena_tx_medida;

    localparam int NDIG = 3;
    localparam int CPB  = 4;
    localparam int PER  = 10 * CPB + 2;
`ifdef TRENA_TX_CRLF_EN
    localparam int K = NDIG + 3;
`else
    localparam int K = NDIG + 1;
`endif
    localparam int MAXO = 400;

    logic        clock = 1'b0;
    logic        reset;
    logic        enviar;
    logic [11:0] medida;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;
    logic [2:0]  db_estado;

    int ciclo  = 0;
    int checks = 0;
    int erros  = 0;

    trena_tx_medida #(
        .N_DIGITOS      (NDIG),
        .CICLOS_POR_BIT (CPB),
        .TERMINADOR     (7'h23)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enviar       (enviar),
        .medida       (medida),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s observado=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    // Reference character k of a message carrying measurement m.
    function automatic logic [6:0] car_esperado(input logic [11:0] m, input int k);
        int d;
        if (k < NDIG) begin
            d = int'((m >> (4 * (NDIG - 1 - k))) & 12'h00F);
            return (d <= 9) ? 7'(48 + d) : 7'h3F;
        end
        if (k == NDIG)     return 7'h23;
        if (k == NDIG + 1) return 7'h0D;
        return 7'h0A;
    endfunction

    // Reference 10-bit frame (LSB sent first): start 0, data, even parity, stop 1.
    function automatic logic [9:0] quadro_esperado(input logic [11:0] m, input int k);
        logic [6:0] c;
        logic       p;
        c = car_esperado(m, k);
        p = (($countones(c) % 2) == 1);
        return {1'b1, p, c, 1'b0};
    endfunction

    // Expected line level o cycles after acceptance edge.
    function automatic logic linha_esperada(input logic [11:0] m, input int o);
        int         p;
        logic [9:0] q;
        p = o - 2;
        if (p < 0 || p >= K * PER) return 1'b1;
        if ((p % PER) >= 10 * CPB) return 1'b1;
        q = quadro_esperado(m, p / PER);
        return q[(p % PER) / CPB];
    endfunction

    // Called #1 after an edge with the DUT idle (or enviar already held).
    task automatic envia_msg(input logic [11:0] val, input bit pulsos, input bit manter);
        logic       lin_s [0:MAXO];
        logic       pr_s  [0:MAXO];
        logic       oc_s  [0:MAXO];
        logic [2:0] es_s  [0:MAXO];
        int         fim;
        int         lin_err;
        int         oc_err;
        int         np;
        int         pp;
        logic [9:0] q_obs;
        enviar = 1'b1;
        medida = val;
        fim = manter ? (1 + K * PER) : (K * PER + 8);
        for (int o = 1; o <= fim; o++) begin
            @(posedge clock);
            #1;
            lin_s[o] = saida_serial;
            pr_s[o]  = pronto;
            oc_s[o]  = ocupado;
            es_s[o]  = db_estado;
            if (o == 1) medida = 12'($urandom);
            if (manter) enviar = 1'b1;
            else enviar = pulsos && (o == 15 || o == 42 || o == 2 * PER + 20);
        end
        verifica("ocupado_inicio", 32'(oc_s[1]), 32'd1);
        verifica("estado_carrega", 32'(es_s[1]), 32'd1);
        verifica("estado_bits", 32'(es_s[2]), 32'd2);
        lin_err = 0;
        for (int o = 1; o <= fim; o++) begin
            if (lin_s[o] !== linha_esperada(val, o)) lin_err++;
        end
        verifica("linha_ciclos_errados", 32'(lin_err), 32'd0);
        for (int k = 0; k < K; k++) begin
            for (int j = 0; j < 10; j++) q_obs[j] = lin_s[2 + k * PER + CPB * j];
            verifica($sformatf("quadro%0d", k), 32'(q_obs), 32'(quadro_esperado(val, k)));
        end
        np = 0;
        pp = -1;
        oc_err = 0;
        for (int o = 1; o <= fim; o++) begin
            if (pr_s[o] === 1'b1) begin
                np++;
                if (pp < 0) pp = o;
            end
            if (o <= 1 + K * PER && oc_s[o] !== 1'b1) oc_err++;
        end
        verifica("pronto_posicao", 32'(pp), 32'(1 + K * PER));
        verifica("pronto_quantidade", 32'(np), 32'd1);
        verifica("ocupado_baixo_no_meio", 32'(oc_err), 32'd0);
        if (!manter) begin
            verifica("ocupado_final", 32'(oc_s[2 + K * PER]), 32'd0);
            verifica("estado_final", 32'(es_s[2 + K * PER]), 32'd0);
        end
    endtask

    task automatic teste_reset(input logic [11:0] val);
        int np;
        int lows;
        enviar = 1'b1;
        medida = val;
        for (int o = 1; o <= 2 + PER + 12; o++) begin
            @(posedge clock);
            #1;
            enviar = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        verifica("reset_saida", 32'(saida_serial), 32'd1);
        verifica("reset_ocupado", 32'(ocupado), 32'd0);
        verifica("reset_estado", 32'(db_estado), 32'd0);
        np = 0;
        lows = 0;
        for (int o = 0; o < K * PER + 10; o++) begin
            @(posedge clock);
            #1;
            if (pronto === 1'b1) np++;
            if (saida_serial !== 1'b1) lows++;
        end
        verifica("reset_sem_pronto", 32'(np), 32'd0);
        verifica("reset_linha_ociosa", 32'(lows), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        enviar = 1'b0;
        medida = 12'h000;
        repeat (3) @(posedge clock);
        #1;
        verifica("rst_saida", 32'(saida_serial), 32'd1);
        verifica("rst_ocupado", 32'(ocupado), 32'd0);
        verifica("rst_pronto", 32'(pronto), 32'd0);
        verifica("rst_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        envia_msg(12'h125, 1'b0, 1'b0);
        envia_msg(12'h9A0, 1'b0, 1'b0);
        envia_msg(12'h125, 1'b1, 1'b0);
        teste_reset(12'h125);
        envia_msg(12'h125, 1'b0, 1'b0);
        // enviar held high across both messages
        envia_msg(12'h042, 1'b0, 1'b1);
        envia_msg(12'($urandom), 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            envia_msg(12'($urandom), 1'($urandom_range(1, 0)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule
